// File: rtl/stack_seq_pkg.sv
// Shared encodings for the stack micro-op sequencer: FSM states, PC-source
// selects, sequence kinds and the trigger opcodes the control unit also decodes.
package stack_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ACCEPT     = 3'd1,
    ST_PUSH_FLAGS = 3'd2,
    ST_PUSH_PC    = 3'd3,
    ST_POP_PC     = 3'd4,
    ST_POP_FLAGS  = 3'd5,
    ST_DRAIN      = 3'd6
  } seq_state_e;

  localparam logic [1:0] JS_NEXT = 2'b00;
  localparam logic [1:0] JS_CALL = 2'b01;
  localparam logic [1:0] JS_VEC  = 2'b10;
  localparam logic [1:0] JS_RET  = 2'b11;

  localparam logic [1:0] SK_NONE = 2'b00;
  localparam logic [1:0] SK_INT  = 2'b01;
  localparam logic [1:0] SK_CALL = 2'b10;
  localparam logic [1:0] SK_RET  = 2'b11;

  localparam logic [5:0] OPCODE_CALL = 6'b100101;
  localparam logic [5:0] OPCODE_RET  = 6'b100110;
  localparam logic [5:0] OPCODE_RETI = 6'b100111;

  // PC source used on the final cycle of a sequence of the given kind.
  function automatic logic [1:0] exit_jump(input logic [1:0] kind);
    case (kind)
      SK_INT:  return JS_VEC;
      SK_CALL: return JS_CALL;
      SK_RET:  return JS_RET;
      default: return JS_NEXT;
    endcase
  endfunction

endpackage

// File: rtl/stack_sequencer_seq_counter.sv
// Loadable up/down counter that saturates at a caller-supplied terminal value
// and flags when it sits there.
module seq_counter #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             count_en,
  input  logic             count_up,
  input  logic [WIDTH-1:0] terminal,
  output logic [WIDTH-1:0] count,
  output logic             at_terminal
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (count_en && (count_q != terminal)) begin
      count_d = count_up ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count       = count_q;
  assign at_terminal = (count_q == terminal);

endmodule

// File: rtl/stack_sequencer.sv
// Decode-stage sequencer for INT entry, CALL, RET and RETI: issues one stack
// push/pop per cycle and stalls fetch until the PC reload on the final cycle.
module stack_sequencer
  import stack_seq_pkg::*;
#(
  parameter int               OPC_W        = 6,
  parameter int               PC_WORDS     = 2,
  parameter int               IDX_W        = (PC_WORDS > 1) ? $clog2(PC_WORDS) : 1,
  parameter int               DRAIN_CYCLES = 3,
  parameter logic [OPC_W-1:0] OP_CALL      = OPC_W'(OPCODE_CALL),
  parameter logic [OPC_W-1:0] OP_RET       = OPC_W'(OPCODE_RET),
  parameter logic [OPC_W-1:0] OP_RETI      = OPC_W'(OPCODE_RETI)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OPC_W-1:0] opcode,
  input  logic             opcode_valid,
  input  logic             interrupt,
  output logic             busy,
  output logic             fd_enable,
  output logic             pc_enable,
  output logic [1:0]       jump_sel,
  output logic             uop_valid,
  output logic             uop_push,
  output logic             uop_flags,
  output logic [IDX_W-1:0] uop_word_idx,
  output logic [1:0]       seq_kind
);

  localparam int               DRAIN_W    = $clog2(DRAIN_CYCLES + 1);
  localparam logic [IDX_W-1:0] WORD_MSW   = IDX_W'(PC_WORDS - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

  seq_state_e state_q, state_d;
  logic [1:0] kind_q, kind_d;
  logic       is_reti_q, is_reti_d;
  logic       int_pending_q, int_pending_d;
  logic       in_seq;

  logic [1:0] trig_kind;
  logic       trig_reti;

  logic             word_load, word_en, word_up, word_tc;
  logic [IDX_W-1:0] word_load_val, word_term, word_cnt;
  logic               drain_load, drain_en, drain_tc;
  logic [DRAIN_W-1:0] drain_cnt;

  assign in_seq = (state_q != ST_IDLE);

  // A pending interrupt outranks any opcode; RET and RETI share one sequence.
  always_comb begin
    trig_kind = SK_NONE;
    trig_reti = 1'b0;
    if (interrupt || int_pending_q) begin
      trig_kind = SK_INT;
    end else if (opcode_valid && (opcode == OP_RETI)) begin
      trig_kind = SK_RET;
      trig_reti = 1'b1;
    end else if (opcode_valid && (opcode == OP_RET)) begin
      trig_kind = SK_RET;
    end else if (opcode_valid && (opcode == OP_CALL)) begin
      trig_kind = SK_CALL;
    end
  end

  always_comb begin
    state_d       = state_q;
    kind_d        = kind_q;
    is_reti_d     = is_reti_q;
    int_pending_d = int_pending_q | (in_seq & interrupt);

    word_load     = 1'b0;
    word_load_val = '0;
    word_en       = 1'b0;
    word_up       = 1'b0;
    word_term     = '0;
    drain_load    = 1'b0;
    drain_en      = 1'b0;

    busy         = in_seq;
    fd_enable    = ~in_seq;
    pc_enable    = ~in_seq;
    jump_sel     = JS_NEXT;
    uop_valid    = 1'b0;
    uop_push     = 1'b0;
    uop_flags    = 1'b0;
    uop_word_idx = '0;
    seq_kind     = in_seq ? kind_q : SK_NONE;

    case (state_q)
      // The accept cycle is IDLE with a trigger present; its stall is combinational.
      ST_IDLE: begin
        if (trig_kind != SK_NONE) begin
          fd_enable = 1'b0;
          pc_enable = 1'b0;
          seq_kind  = trig_kind;
          kind_d    = trig_kind;
          is_reti_d = trig_reti;
          case (trig_kind)
            SK_INT: begin
              state_d       = ST_PUSH_FLAGS;
              int_pending_d = 1'b0;
            end
            SK_CALL: begin
              state_d       = ST_PUSH_PC;
              word_load     = 1'b1;
              word_load_val = WORD_MSW;
            end
            default: begin
              state_d       = ST_POP_PC;
              word_load     = 1'b1;
              word_load_val = '0;
            end
          endcase
        end
      end

      ST_PUSH_FLAGS: begin
        uop_valid     = 1'b1;
        uop_push      = 1'b1;
        uop_flags     = 1'b1;
        state_d       = ST_PUSH_PC;
        word_load     = 1'b1;
        word_load_val = WORD_MSW;
      end

      ST_PUSH_PC: begin
        uop_valid    = 1'b1;
        uop_push     = 1'b1;
        uop_word_idx = word_cnt;
        word_term    = '0;
        if (word_tc) begin
          fd_enable = 1'b1;
          pc_enable = 1'b1;
          jump_sel  = exit_jump(kind_q);
          state_d   = ST_IDLE;
        end else begin
          word_en = 1'b1;
        end
      end

      ST_POP_PC: begin
        uop_valid    = 1'b1;
        uop_word_idx = word_cnt;
        word_term    = WORD_MSW;
        word_up      = 1'b1;
        if (word_tc) begin
          if (is_reti_q) begin
            state_d = ST_POP_FLAGS;
          end else begin
            state_d    = ST_DRAIN;
            drain_load = 1'b1;
          end
        end else begin
          word_en = 1'b1;
        end
      end

      ST_POP_FLAGS: begin
        uop_valid  = 1'b1;
        uop_flags  = 1'b1;
        state_d    = ST_DRAIN;
        drain_load = 1'b1;
      end

      // Gives the popped PC words time to reach writeback before the reload.
      ST_DRAIN: begin
        if (drain_tc) begin
          fd_enable = 1'b1;
          pc_enable = 1'b1;
          jump_sel  = exit_jump(kind_q);
          state_d   = ST_IDLE;
        end else begin
          drain_en = (drain_cnt < DRAIN_LAST);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (rst) begin
      busy         = 1'b0;
      fd_enable    = 1'b1;
      pc_enable    = 1'b1;
      jump_sel     = JS_NEXT;
      uop_valid    = 1'b0;
      uop_push     = 1'b0;
      uop_flags    = 1'b0;
      uop_word_idx = '0;
      seq_kind     = SK_NONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      kind_q        <= SK_NONE;
      is_reti_q     <= 1'b0;
      int_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      kind_q        <= kind_d;
      is_reti_q     <= is_reti_d;
      int_pending_q <= int_pending_d;
    end
  end

  seq_counter #(.WIDTH(IDX_W)) u_word_cnt (
    .clk        (clk),
    .rst        (rst),
    .load       (word_load),
    .load_value (word_load_val),
    .count_en   (word_en),
    .count_up   (word_up),
    .terminal   (word_term),
    .count      (word_cnt),
    .at_terminal(word_tc)
  );

  seq_counter #(.WIDTH(DRAIN_W)) u_drain_cnt (
    .clk        (clk),
    .rst        (rst),
    .load       (drain_load),
    .load_value ('0),
    .count_en   (drain_en),
    .count_up   (1'b1),
    .terminal   (DRAIN_LAST),
    .count      (drain_cnt),
    .at_terminal(drain_tc)
  );

endmodule

// File: tb/tb_stack_sequencer.sv
// Bench for stack_sequencer: a per-cycle scripted reference model checked on
// every negedge, directed latency checks, then randomized traffic.
module tb_stack_sequencer;

  localparam int P  = 2;
  localparam int D  = 3;
  localparam int IW = 1;

  localparam logic [5:0] C_CALL = 6'b100101;
  localparam logic [5:0] C_RET  = 6'b100110;
  localparam logic [5:0] C_RETI = 6'b100111;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [5:0]    opcode = 6'd0;
  logic          opcode_valid = 1'b0;
  logic          interrupt = 1'b0;
  logic          busy, fd_enable, pc_enable, uop_valid, uop_push, uop_flags;
  logic [1:0]    jump_sel, seq_kind;
  logic [IW-1:0] uop_word_idx;

  always #5 clk = ~clk;

  stack_sequencer #(
    .OPC_W(6), .PC_WORDS(P), .IDX_W(IW), .DRAIN_CYCLES(D)
  ) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .opcode_valid(opcode_valid),
    .interrupt(interrupt), .busy(busy), .fd_enable(fd_enable),
    .pc_enable(pc_enable), .jump_sel(jump_sel), .uop_valid(uop_valid),
    .uop_push(uop_push), .uop_flags(uop_flags), .uop_word_idx(uop_word_idx),
    .seq_kind(seq_kind)
  );

  int total = 0;
  int bad   = 0;

  function automatic void chk(input string name, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s t=%0t got=%0d want=%0d", name, $time, act, want);
    end
  endfunction

  typedef struct packed {
    logic          busy, fd, pc;
    logic [1:0]    js;
    logic          uv, push, flags;
    logic [IW-1:0] idx;
    logic [1:0]    kind;
    logic          chk_kind;
    logic          full;
  } exp_t;

  exp_t script[$];
  bit   pend = 1'b0;

  function automatic exp_t mk(input logic b, input logic fd, input logic pc,
                              input logic [1:0] js, input logic uv, input logic push,
                              input logic flags, input int idx, input logic [1:0] kind,
                              input logic chk_kind);
    exp_t e;
    e.busy = b; e.fd = fd; e.pc = pc; e.js = js; e.uv = uv; e.push = push;
    e.flags = flags; e.idx = IW'(idx); e.kind = kind; e.chk_kind = chk_kind;
    e.full = 1'b0;
    return e;
  endfunction

  // Whole sequence after the accept cycle, one record per cycle.
  function automatic void build(input logic [1:0] kind, input bit reti);
    if (kind == 2'b01) script.push_back(mk(1, 0, 0, 2'b00, 1, 1, 1, 0, kind, 1));
    if (kind != 2'b11) begin
      for (int w = P - 1; w >= 0; w--)
        script.push_back(mk(1, w == 0, w == 0, (w == 0) ? ((kind == 2'b01) ? 2'b10 : 2'b01) : 2'b00,
                            1, 1, 0, w, kind, 1));
    end else begin
      for (int w = 0; w < P; w++) script.push_back(mk(1, 0, 0, 2'b00, 1, 0, 0, w, kind, 1));
      if (reti) script.push_back(mk(1, 0, 0, 2'b00, 1, 0, 1, 0, kind, 1));
      for (int d = 0; d < D; d++)
        script.push_back(mk(1, d == D - 1, d == D - 1, (d == D - 1) ? 2'b11 : 2'b00,
                            0, 0, 0, 0, kind, 1));
    end
  endfunction

  always @(negedge clk) begin : cmp
    exp_t e;
    if (rst) begin
      e = mk(0, 1, 1, 2'b00, 0, 0, 0, 0, 2'b00, 1);
      e.full = 1'b1;
      script.delete();
      pend = 1'b0;
    end else if (script.size() == 0) begin
      e = mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 0);
      if (interrupt || pend) begin
        build(2'b01, 0);
        pend = 1'b0;
      end else if (opcode_valid && opcode == C_RETI) build(2'b11, 1);
      else if (opcode_valid && opcode == C_RET)     build(2'b11, 0);
      else if (opcode_valid && opcode == C_CALL)    build(2'b10, 0);
      else e = mk(0, 1, 1, 2'b00, 0, 0, 0, 0, 2'b00, 1);
    end else begin
      e = script.pop_front();
      if (interrupt) pend = 1'b1;
    end
    chk("busy", busy, e.busy);
    chk("fd_enable", fd_enable, e.fd);
    chk("pc_enable", pc_enable, e.pc);
    chk("jump_sel", jump_sel, e.js);
    chk("uop_valid", uop_valid, e.uv);
    if (e.full || e.uv) begin
      chk("uop_push", uop_push, e.push);
      chk("uop_flags", uop_flags, e.flags);
    end
    if (e.full || (e.uv && !e.flags)) chk("uop_word_idx", uop_word_idx, e.idx);
    if (e.chk_kind) chk("seq_kind", seq_kind, e.kind);
  end

  // Directed: trigger one sequence, count cycles from accept to the PC reload.
  task automatic run_seq(input string name, input logic [5:0] op, input logic irq,
                         input int exp_len, input logic [1:0] exp_js, input int pulse_at);
    int n;
    bit done;
    @(posedge clk); #1;
    opcode = op; opcode_valid = 1'b1; interrupt = irq;
    @(negedge clk);
    chk({name, "_acc_busy"}, busy, 0);
    chk({name, "_acc_fd"}, fd_enable, 0);
    chk({name, "_acc_pc"}, pc_enable, 0);
    n = 1;
    done = 1'b0;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      opcode = 6'd0; opcode_valid = 1'b0; interrupt = (pulse_at == n + 1);
      @(negedge clk);
      n++;
      if (busy && pc_enable) done = 1'b1;
    end
    chk({name, "_len"}, n, exp_len);
    chk({name, "_jsel"}, jump_sel, exp_js);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    run_seq("call", C_CALL, 1'b0, 3, 2'b01, 0);
    run_seq("ret", C_RET, 1'b0, 6, 2'b11, 0);
    run_seq("reti", C_RETI, 1'b0, 7, 2'b11, 0);
    run_seq("int_over_call", C_CALL, 1'b1, 4, 2'b10, 0);

    // Interrupt pulsed in the second drain cycle must start INT straight after.
    run_seq("ret_q", C_RET, 1'b0, 6, 2'b11, 5);
    @(posedge clk); #1 interrupt = 1'b0;
    @(negedge clk);
    chk("queued_acc_busy", busy, 0);
    chk("queued_acc_fd", fd_enable, 0);
    @(negedge clk);
    chk("queued_flags_push", {uop_valid, uop_push, uop_flags}, 3'b111);
    n = 0;
    while (busy && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("queued_done", busy, 0);

    // Reset mid-RET with an interrupt already queued: both are forgotten.
    @(posedge clk); #1 opcode = C_RET; opcode_valid = 1'b1;
    @(posedge clk); #1 opcode_valid = 1'b0; interrupt = 1'b1;
    @(posedge clk); #1 interrupt = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_fd", fd_enable, 1);
    chk("post_rst_pc", pc_enable, 1);
    chk("post_rst_uv", uop_valid, 0);

    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      rst          = ($urandom_range(0, 199) == 0);
      opcode_valid = $urandom_range(0, 1) == 1;
      interrupt    = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 3))
        0:       opcode = C_CALL;
        1:       opcode = C_RET;
        2:       opcode = C_RETI;
        default: opcode = 6'($urandom_range(0, 63));
      endcase
    end
    @(posedge clk); #1;
    rst = 1'b0; opcode_valid = 1'b0; interrupt = 1'b0;
    @(negedge clk);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
